// File: rtl/imem_pkg.sv
// Shared constants and helper functions for the imem_fetch instruction memory.
package imem_pkg;

  localparam logic [31:0] FAULT_WORD_DEFAULT = 32'h0000_0013;

  // Bits needed to index a memory of 'depth' words; never less than one.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Byte-offset bits inside one instruction word when the PC is a byte address.
  function automatic int word_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/imem_rsp_fifo2.sv
// Two-entry response buffer; the head entry drives the outputs and stays put until popped.
module imem_rsp_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [1:0]   count_o,
  output logic [W-1:0] data_o
);

  logic [W-1:0] head_q, tail_q;
  logic [1:0]   cnt_q;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= data_i;
          else               tail_q <= data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= data_i;
          end else begin
            head_q <= tail_q;
            tail_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;
  assign data_o  = head_q;

endmodule

// File: rtl/imem_fetch.sv
// Synchronous-read instruction memory with valid/ready fetch, 2-deep response buffer and load port.
// Define IMEM_PERF_EN to add o_fetch_cnt / o_stall_cnt performance counters.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 32,
  parameter int                 DEPTH      = 256,
  parameter                     INIT_FILE  = "",
  parameter int                 BYTE_ADDR  = 0,
  parameter logic [DATA_W-1:0]  FAULT_WORD = DATA_W'(FAULT_WORD_DEFAULT)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_instruction,
  output logic [ADDR_W-1:0] o_rsp_pc,
  output logic              o_fault,
`ifdef IMEM_PERF_EN
  output logic [31:0]       o_fetch_cnt,
  output logic [31:0]       o_stall_cnt,
`endif
  input  logic              i_ld_en,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam int OFF_W = (BYTE_ADDR != 0) ? word_off_w(DATA_W) : 0;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_fault;
  logic [DATA_W-1:0] rd_word;
  logic              accept, deliver;
  logic [1:0]        fifo_cnt;
  logic [ENT_W-1:0]  fifo_out;

  // NOTE: the memory array has no reset; only control and output registers are cleared.
  always_ff @(posedge i_clk) begin
    if (i_ld_en && ({1'b0, i_ld_addr} < DEPTH_L)) mem[i_ld_addr[IDX_W-1:0]] <= i_ld_data;
  end

  assign rd_idx   = i_pc >> OFF_W;
  assign rd_fault = ({1'b0, rd_idx} >= DEPTH_L) || ((rd_idx << OFF_W) != i_pc);

  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    rd_word = FAULT_WORD;
    if (!rd_fault) rd_word = mem[rd_idx[IDX_W-1:0]];
  end

  // Load cycles block fetch accept, so a read never meets a write to the same word.
  assign o_req_ready = (fifo_cnt != 2'd2) && !i_ld_en;
  assign accept      = i_req_valid && o_req_ready;
  assign deliver     = o_rsp_valid && i_rsp_ready;

  imem_rsp_fifo2 #(.W(ENT_W)) u_rsp_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (accept),
    .pop_i   (deliver),
    .data_i  ({rd_fault, i_pc, rd_word}),
    .valid_o (o_rsp_valid),
    .count_o (fifo_cnt),
    .data_o  (fifo_out)
  );

  assign {o_fault, o_rsp_pc, o_instruction} = fifo_out;

`ifdef IMEM_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (deliver && !o_fault)           fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (i_req_valid && !o_req_ready)   stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench: word-indexed and byte-addressed instances driven in lockstep against a queue model.
module tb_imem_fetch;

  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } rsp_t;

  logic        clk, rst, req_valid, rsp_ready, ld_en;
  logic [31:0] pc, ld_addr, ld_data;
  logic [1:0]  req_ready, rsp_valid, fault;
  logic [31:0] instr [2];
  logic [31:0] rsp_pc [2];
`ifdef IMEM_PERF_EN
  logic [31:0] fetch_cnt [2];
  logic [31:0] stall_cnt [2];
  logic [31:0] fetch_w, fetch_b, stall_m;
`endif

  logic [31:0] mem_m [256];
  rsp_t        q0[$], q1[$];
  int          n_chk = 0, n_err = 0;
  bit          chk_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    imem_fetch #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(256), .INIT_FILE(""),
      .BYTE_ADDR(k), .FAULT_WORD(32'h0000_0013)
    ) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready[k]), .i_pc(pc),
      .o_rsp_valid(rsp_valid[k]), .i_rsp_ready(rsp_ready),
      .o_instruction(instr[k]), .o_rsp_pc(rsp_pc[k]), .o_fault(fault[k]),
`ifdef IMEM_PERF_EN
      .o_fetch_cnt(fetch_cnt[k]), .o_stall_cnt(stall_cnt[k]),
`endif
      .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected response straight from the addressing rules.
  function automatic rsp_t predict(input bit byte_mode, input logic [31:0] a);
    rsp_t   r;
    longint idx;
    idx     = byte_mode ? longint'(a / 4) : longint'(a);
    r.pc    = a;
    r.fault = (idx >= 256) || (byte_mode && (a % 4 != 0));
    r.instr = r.fault ? 32'h13 : mem_m[idx[7:0]];
    return r;
  endfunction

  task automatic pop_both();
`ifdef IMEM_PERF_EN
    if (!q0[0].fault) fetch_w <= fetch_w + 1;
    if (!q1[0].fault) fetch_b <= fetch_b + 1;
`endif
    void'(q0.pop_front());
    void'(q1.pop_front());
  endtask

  // Model update at each rising edge, using the values the DUT samples.
  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
`ifdef IMEM_PERF_EN
      fetch_w <= 0; fetch_b <= 0; stall_m <= 0;
`endif
    end else begin
`ifdef IMEM_PERF_EN
      if (req_valid && !(q0.size() < 2 && !ld_en)) stall_m <= stall_m + 1;
`endif
      if (req_valid && q0.size() < 2 && !ld_en) begin
        if (q0.size() > 0 && rsp_ready) pop_both();
        q0.push_back(predict(1'b0, pc));
        q1.push_back(predict(1'b1, pc));
      end else if (q0.size() > 0 && rsp_ready) begin
        pop_both();
      end
    end
    if (ld_en && ld_addr < 256) mem_m[ld_addr[7:0]] <= ld_data;
  end

  task automatic cmp_inst(input string tag, input int k, input int qsz, input rsp_t head);
    check({"req_ready_", tag}, 64'(req_ready[k]), 64'((qsz < 2) && !ld_en));
    check({"rsp_valid_", tag}, 64'(rsp_valid[k]), 64'(qsz != 0));
    if (qsz != 0) begin
      check({"instr_", tag}, 64'(instr[k]), 64'(head.instr));
      check({"rsp_pc_", tag}, 64'(rsp_pc[k]), 64'(head.pc));
      check({"fault_", tag}, 64'(fault[k]), 64'(head.fault));
    end
  endtask

  // Compare process: every falling edge once the bench has left initial reset.
  always @(negedge clk) begin
    if (chk_en) begin
      if (q0.size() != 0) cmp_inst("w", 0, q0.size(), q0[0]);
      else                cmp_inst("w", 0, 0, '0);
      if (q1.size() != 0) cmp_inst("b", 1, q1.size(), q1[0]);
      else                cmp_inst("b", 1, 0, '0);
`ifdef IMEM_PERF_EN
      check("fetch_cnt_w", 64'(fetch_cnt[0]), 64'(fetch_w));
      check("fetch_cnt_b", 64'(fetch_cnt[1]), 64'(fetch_b));
      check("stall_cnt_w", 64'(stall_cnt[0]), 64'(stall_m));
      check("stall_cnt_b", 64'(stall_cnt[1]), 64'(stall_m));
`endif
    end
  end

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({"rst_valid_", tag}, 64'(rsp_valid[k]), 64'(0));
      check({"rst_instr_", tag}, 64'(instr[k]), 64'(0));
      check({"rst_pc_", tag}, 64'(rsp_pc[k]), 64'(0));
      check({"rst_fault_", tag}, 64'(fault[k]), 64'(0));
      check({"rst_ready_", tag}, 64'(req_ready[k]), 64'(1));
`ifdef IMEM_PERF_EN
      check({"rst_fetch_cnt_", tag}, 64'(fetch_cnt[k]), 64'(0));
      check({"rst_stall_cnt_", tag}, 64'(stall_cnt[k]), 64'(0));
`endif
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; ld_en = 1'b0;
    pc = '0; ld_addr = '0; ld_data = '0;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    check_reset_state("init");
    chk_en = 1'b1;

    // Program the whole memory through the load port.
    for (int i = 0; i < 256; i++) begin
      ld_en = 1'b1; ld_addr = 32'(i);
      ld_data = (i < 4) ? 32'((i + 1) * 32'h11) : $urandom;
      cyc();
    end
    ld_en = 1'b0;
    cyc();

    // Back-to-back fetches with the consumer always ready.
    rsp_ready = 1'b1; req_valid = 1'b1;
    pc = 0; cyc(); check("b2b_0", 64'(instr[0]), 64'h11); check("b2b_rdy0", 64'(req_ready[0]), 64'(1));
    pc = 1; cyc(); check("b2b_1", 64'(instr[0]), 64'h22); check("b2b_rdy1", 64'(req_ready[0]), 64'(1));
    pc = 2; cyc(); check("b2b_2", 64'(instr[0]), 64'h33); check("b2b_v2", 64'(rsp_valid[0]), 64'(1));
    req_valid = 1'b0; cyc();

    // Back-pressure: two buffered, third held until space frees up.
    rsp_ready = 1'b0; req_valid = 1'b1;
    pc = 0; cyc();
    pc = 1; cyc(); check("bp_full_rdy", 64'(req_ready[0]), 64'(0));
    pc = 2; cyc(); check("bp_hold_instr", 64'(instr[0]), 64'h11); check("bp_hold_pc", 64'(rsp_pc[0]), 64'(0));
    rsp_ready = 1'b1;
    cyc(); check("bp_instr1", 64'(instr[0]), 64'h22); check("bp_pc1", 64'(rsp_pc[0]), 64'(1));
    cyc(); check("bp_instr2", 64'(instr[0]), 64'h33); check("bp_pc2", 64'(rsp_pc[0]), 64'(2));
    req_valid = 1'b0;
    cyc(); check("bp_drained", 64'(rsp_valid[0]), 64'(0));

    // Out-of-range fault, then a normal fetch.
    req_valid = 1'b1;
    pc = 256; cyc();
    check("oor_fault", 64'(fault[0]), 64'(1)); check("oor_instr", 64'(instr[0]), 64'h13);
    check("oor_pc", 64'(rsp_pc[0]), 64'(256));
    pc = 3; cyc(); check("after_oor_instr", 64'(instr[0]), 64'h44); check("after_oor_fault", 64'(fault[0]), 64'(0));

    // Byte-address instance: aligned and misaligned.
    pc = 8; cyc(); check("byte_aligned", 64'(instr[1]), 64'h33); check("byte_aligned_f", 64'(fault[1]), 64'(0));
    pc = 6; cyc(); check("byte_misal_f", 64'(fault[1]), 64'(1)); check("byte_misal_i", 64'(instr[1]), 64'h13);
    req_valid = 1'b0; cyc();

    // Load cycle blocks accept; the next fetch sees the new word.
    ld_en = 1'b1; ld_addr = 5; ld_data = 32'hDEADBEEF; req_valid = 1'b1; pc = 0;
    #1 check("ld_block_rdy", 64'(req_ready[0]), 64'(0));
    cyc();
    ld_en = 1'b0; pc = 5;
    cyc(); check("ld_readback", 64'(instr[0]), 64'hDEADBEEF);
    req_valid = 1'b0; cyc();

    // Randomised traffic, including out-of-range loads and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst       = ($urandom_range(0, 299) == 0);
      ld_en     = !rst && ($urandom_range(0, 9) == 0);
      ld_addr   = ($urandom_range(0, 7) == 0) ? 32'(256 + $urandom_range(0, 100)) : 32'($urandom_range(0, 15));
      ld_data   = $urandom;
      req_valid = ($urandom_range(0, 9) < 7);
      rsp_ready = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 9);
      if (r < 6)      pc = 32'($urandom_range(0, 15));
      else if (r < 8) pc = 32'($urandom_range(0, 63));
      else            pc = 32'($urandom_range(250, 1100));
      cyc();
    end
    rst = 1'b0; ld_en = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) cyc();

    // Reset with two responses buffered.
    rsp_ready = 1'b0; req_valid = 1'b1;
    pc = 0; cyc();
    pc = 1; cyc();
    check("pre_rst_valid", 64'(rsp_valid[0]), 64'(1));
    req_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_state("mid");
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
